// File: rtl/car_pkg.sv
// Shared definitions for the car controller: executor states, default timing
// constants and the turn-trigger priority encoding shared with semi_auto.
package car_pkg;

    localparam int TURN_CYCLES_DEF   = 450;  // 0.9 s at 500 Hz
    localparam int SETTLE_CYCLES_DEF = 50;   // 0.1 s at 500 Hz

    typedef enum logic [2:0] {
        IDLE,
        TURN_L,
        TURN_R,
        TURN_BACK,
        SETTLE
    } turn_state_e;

    typedef enum logic [1:0] {
        TRIG_NONE,
        TRIG_LEFT,
        TRIG_RIGHT,
        TRIG_BACK
    } trig_e;

    // Fixed priority: back > left > right; lower-priority requests are dropped
    function automatic trig_e trig_select(input logic left,
                                          input logic right,
                                          input logic back);
        if (back)
            return TRIG_BACK;
        else if (left)
            return TRIG_LEFT;
        else if (right)
            return TRIG_RIGHT;
        return TRIG_NONE;
    endfunction

endpackage

// File: rtl/turn_timer.sv
// Loadable down-counter: counts from the load value to zero without wrapping
// and flags the last counted cycle (value == 1) with a one-cycle expire pulse.
module turn_timer #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic [CNT_W-1:0] value,
    output logic             expire
);

    // Counter register: clear beats load, load beats decrement, stop at zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            value <= '0;
        else if (clear)
            value <= '0;
        else if (load)
            value <= load_val;
        else if (value != '0)
            value <= value - CNT_W'(1);
    end

    assign expire = (value == CNT_W'(1));

endmodule

// File: rtl/turn_executor.sv
// Timed in-place turn sequencer: accepts one left/right/back request while
// idle, drives the spin command for the turn duration, holds through a settle
// window and pulses turn_done on return to idle.
module turn_executor
    import car_pkg::*;
#(
    parameter int TURN_CYCLES   = TURN_CYCLES_DEF,
    parameter int SETTLE_CYCLES = SETTLE_CYCLES_DEF,
    parameter int CNT_W         = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic enable,
    input  logic trigger_turn_left,
    input  logic trigger_turn_right,
    input  logic trigger_turn_back,
    output logic is_turning,
    output logic spin_left,
    output logic spin_right,
    output logic turn_done
);

    localparam logic [CNT_W-1:0] TURN_LOAD   = CNT_W'(TURN_CYCLES);
    localparam logic [CNT_W-1:0] BACK_LOAD   = CNT_W'(2 * TURN_CYCLES);
    localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES);

    if (((64'(2 * TURN_CYCLES) >> CNT_W) != 64'd0) || (TURN_CYCLES < 1)) begin : g_cnt_w_check
        $error("turn_executor: 2*TURN_CYCLES must fit in CNT_W bits and TURN_CYCLES must be >= 1");
    end

    turn_state_e      state;
    trig_e            trig;
    logic             timer_load;
    logic [CNT_W-1:0] timer_load_val;
    logic [CNT_W-1:0] timer_value;
    logic             timer_expire;

    turn_timer #(
        .CNT_W(CNT_W)
    ) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (!enable),
        .load     (timer_load),
        .load_val (timer_load_val),
        .value    (timer_value),
        .expire   (timer_expire)
    );

    // Resolve simultaneous requests into a single turn kind
    always_comb begin
        trig = trig_select(trigger_turn_left, trigger_turn_right, trigger_turn_back);
    end

    // Timer reload: on turn acceptance and on the turn-to-settle transition
    always_comb begin
        timer_load     = 1'b0;
        timer_load_val = '0;
        case (state)
            IDLE: begin
                if (trig == TRIG_BACK) begin
                    timer_load     = 1'b1;
                    timer_load_val = BACK_LOAD;
                end else if (trig != TRIG_NONE) begin
                    timer_load     = 1'b1;
                    timer_load_val = TURN_LOAD;
                end
            end
            TURN_L, TURN_R, TURN_BACK: begin
                if (timer_expire && (SETTLE_CYCLES != 0)) begin
                    timer_load     = 1'b1;
                    timer_load_val = SETTLE_LOAD;
                end
            end
            default: ;
        endcase
    end

    // Sequencer with registered outputs; enable low aborts without turn_done
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            is_turning <= 1'b0;
            spin_left  <= 1'b0;
            spin_right <= 1'b0;
            turn_done  <= 1'b0;
        end else if (!enable) begin
            state      <= IDLE;
            is_turning <= 1'b0;
            spin_left  <= 1'b0;
            spin_right <= 1'b0;
            turn_done  <= 1'b0;
        end else begin
            turn_done <= 1'b0;
            case (state)
                IDLE: begin
                    case (trig)
                        TRIG_BACK: begin
                            state      <= TURN_BACK;
                            is_turning <= 1'b1;
                            spin_right <= 1'b1;
                        end
                        TRIG_LEFT: begin
                            state      <= TURN_L;
                            is_turning <= 1'b1;
                            spin_left  <= 1'b1;
                        end
                        TRIG_RIGHT: begin
                            state      <= TURN_R;
                            is_turning <= 1'b1;
                            spin_right <= 1'b1;
                        end
                        default: ;
                    endcase
                end
                TURN_L, TURN_R, TURN_BACK: begin
                    if (timer_expire) begin
                        spin_left  <= 1'b0;
                        spin_right <= 1'b0;
                        if (SETTLE_CYCLES == 0) begin
                            state      <= IDLE;
                            is_turning <= 1'b0;
                            turn_done  <= 1'b1;
                        end else begin
                            state <= SETTLE;
                        end
                    end
                end
                SETTLE: begin
                    if (timer_expire) begin
                        state      <= IDLE;
                        is_turning <= 1'b0;
                        turn_done  <= 1'b1;
                    end
                end
                default: begin
                    state      <= IDLE;
                    is_turning <= 1'b0;
                    spin_left  <= 1'b0;
                    spin_right <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_turn_executor.sv
// Directed bench for turn_executor with TURN_CYCLES=4, SETTLE_CYCLES=2, plus a
// second instance with SETTLE_CYCLES=0 sharing the same stimulus.
module tb_turn_executor;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic enable = 1'b0;
    logic trig_l = 1'b0;
    logic trig_r = 1'b0;
    logic trig_b = 1'b0;

    logic is_turning, spin_left, spin_right, turn_done;
    logic z_is_turning, z_spin_left, z_spin_right, z_turn_done;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    turn_executor #(
        .TURN_CYCLES   (4),
        .SETTLE_CYCLES (2),
        .CNT_W         (8)
    ) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .enable             (enable),
        .trigger_turn_left  (trig_l),
        .trigger_turn_right (trig_r),
        .trigger_turn_back  (trig_b),
        .is_turning         (is_turning),
        .spin_left          (spin_left),
        .spin_right         (spin_right),
        .turn_done          (turn_done)
    );

    turn_executor #(
        .TURN_CYCLES   (4),
        .SETTLE_CYCLES (0),
        .CNT_W         (8)
    ) dut_nosettle (
        .clk                (clk),
        .rst_n              (rst_n),
        .enable             (enable),
        .trigger_turn_left  (trig_l),
        .trigger_turn_right (trig_r),
        .trigger_turn_back  (trig_b),
        .is_turning         (z_is_turning),
        .spin_left          (z_spin_left),
        .spin_right         (z_spin_right),
        .turn_done          (z_turn_done)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Apply {back,left,right} requests per cycle and tally the output activity
    task automatic run_and_check(input string tag,
                                 input logic [2:0] first, input bit hold,
                                 input int k2, input logic [2:0] second,
                                 input int cycles,
                                 input int exp_busy, input int exp_l,
                                 input int exp_r, input int exp_done);
        int n_busy = 0, n_l = 0, n_r = 0, n_done = 0, n_both = 0;
        logic [2:0] lines;
        for (int i = 0; i < cycles; i++) begin
            lines = (i == 0 || hold) ? first : 3'b000;
            if (i == k2) lines = lines | second;
            {trig_b, trig_l, trig_r} = lines;
            tick();
            n_busy += int'(is_turning);
            n_l    += int'(spin_left);
            n_r    += int'(spin_right);
            n_done += int'(turn_done);
            n_both += int'(spin_left & spin_right);
        end
        {trig_b, trig_l, trig_r} = 3'b000;
        check({tag, "_busy"}, n_busy, exp_busy);
        check({tag, "_spin_l"}, n_l, exp_l);
        check({tag, "_spin_r"}, n_r, exp_r);
        check({tag, "_done"}, n_done, exp_done);
        check({tag, "_both"}, n_both, 0);
    endtask

    int exp_busy[8]   = '{1, 1, 1, 1, 1, 1, 0, 0};
    int exp_spl[8]    = '{1, 1, 1, 1, 0, 0, 0, 0};
    int exp_done[8]   = '{0, 0, 0, 0, 0, 0, 1, 0};
    int exp_zbusy[8]  = '{1, 1, 1, 1, 0, 0, 0, 0};
    int exp_zdone[8]  = '{0, 0, 0, 0, 1, 0, 0, 0};

    initial begin
        // Reset state
        tick();
        tick();
        check("rst_busy", is_turning, 0);
        check("rst_spin_l", spin_left, 0);
        check("rst_spin_r", spin_right, 0);
        check("rst_done", turn_done, 0);
        rst_n  = 1'b1;
        enable = 1'b1;
        tick();

        // Single-cycle left pulse, cycle-exact for both instances
        trig_l = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            trig_l = 1'b0;
            check($sformatf("left_busy_c%0d", i), is_turning, exp_busy[i]);
            check($sformatf("left_spin_l_c%0d", i), spin_left, exp_spl[i]);
            check($sformatf("left_spin_r_c%0d", i), spin_right, 0);
            check($sformatf("left_done_c%0d", i), turn_done, exp_done[i]);
            check($sformatf("nosettle_busy_c%0d", i), z_is_turning, exp_zbusy[i]);
            check($sformatf("nosettle_spin_l_c%0d", i), z_spin_left, exp_zbusy[i]);
            check($sformatf("nosettle_done_c%0d", i), z_turn_done, exp_zdone[i]);
        end

        // Back turn, then all three requests in one cycle
        run_and_check("back", 3'b100, 1'b0, -1, 3'b000, 16, 10, 0, 8, 1);
        run_and_check("all3", 3'b111, 1'b0, -1, 3'b000, 16, 10, 0, 8, 1);
        // Right pulse during an active left turn is dropped
        run_and_check("left_then_r", 3'b010, 1'b0, 2, 3'b001, 16, 6, 4, 0, 1);
        // Plain right turn
        run_and_check("right", 3'b001, 1'b0, -1, 3'b000, 16, 6, 0, 4, 1);
        // Held left request restarts one edge after each return to idle
        run_and_check("held_left", 3'b010, 1'b1, -1, 3'b000, 20, 18, 12, 0, 2);
        for (int i = 0; i < 12; i++) tick();
        check("held_drained", is_turning, 0);

        // Enable dropped in the third cycle of a turn
        trig_l = 1'b1;
        tick();
        trig_l = 1'b0;
        tick();
        tick();
        check("en_mid_spin_l", spin_left, 1);
        enable = 1'b0;
        tick();
        check("en_off_busy", is_turning, 0);
        check("en_off_spin_l", spin_left, 0);
        check("en_off_spin_r", spin_right, 0);
        check("en_off_done", turn_done, 0);
        tick();
        check("en_off_done2", turn_done, 0);
        enable = 1'b1;
        run_and_check("en_fresh", 3'b010, 1'b0, -1, 3'b000, 16, 6, 4, 0, 1);

        // Asynchronous reset mid right turn
        trig_r = 1'b1;
        tick();
        trig_r = 1'b0;
        tick();
        check("rst_mid_spin_r_before", spin_right, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_mid_busy", is_turning, 0);
        check("rst_mid_spin_r", spin_right, 0);
        check("rst_mid_done", turn_done, 0);
        tick();
        rst_n = 1'b1;
        run_and_check("post_rst_left", 3'b010, 1'b0, -1, 3'b000, 16, 6, 4, 0, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
